// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exec_sequencer
//  Purpose  : Multicycle execute/control stage in front of an 8x8 register
//             file. Accepts one instruction per valid/ready handshake, reads
//             rs1/rs2 through the file's single registered read port, runs an
//             8-bit ALU operation and writes the result back to rd.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             instr_valid/ready     - instruction handshake (ready only in IDLE)
//             instr[15:0]           - {opcode, rd, rs1, rs2, -} or {8, rd, imm8}
//             rf_read_addr          - register file read address
//             rf_data_out           - register file read data (1-cycle latency)
//             rf_write_addr/data_in/write_enable - register file write port
//             done, illegal         - retire pulse / undefined-opcode pulse
//             zero_flag, carry_flag - condition flags
//  Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [15:0]               instr,
    output logic [REG_ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0]     rf_data_out,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_data_in,
    output logic                      rf_write_enable,
    output logic                      done,
    output logic                      illegal,
    output logic                      zero_flag,
    output logic                      carry_flag
);

    localparam logic [3:0] c_OP_NOP = 4'd0;
    localparam logic [3:0] c_OP_ADD = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd2;
    localparam logic [3:0] c_OP_AND = 4'd3;
    localparam logic [3:0] c_OP_OR  = 4'd4;
    localparam logic [3:0] c_OP_XOR = 4'd5;
    localparam logic [3:0] c_OP_SHL = 4'd6;
    localparam logic [3:0] c_OP_SHR = 4'd7;
    localparam logic [3:0] c_OP_LDI = 4'd8;
    localparam logic [3:0] c_OP_MOV = 4'd9;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD_A = 3'd1;
    localparam logic [2:0] c_ST_RD_B = 3'd2;
    localparam logic [2:0] c_ST_EXEC = 3'd3;
    localparam logic [2:0] c_ST_WB   = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [15:0]           r_instr;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_carry;
    logic                  r_done;
    logic                  r_illegal;

    logic [3:0]            w_op;
    logic [3:0]            w_in_op;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_alu_carry;
    logic                  w_carry_upd;
    logic                  w_accept;
    logic                  w_wb_write;

    // Ops that need both register reads and the EXEC cycle.
    function automatic logic f_is_alu(input logic [3:0] op);
        return ((op >= c_OP_ADD) && (op <= c_OP_SHR)) || (op == c_OP_MOV);
    endfunction

    assign w_op     = r_instr[15:12];
    assign w_in_op  = instr[15:12];
    assign w_accept = (r_state == c_ST_IDLE) && instr_valid;

    // ALU: opb comes straight from the read port during EXEC (rs2 was
    // addressed in RD_B).
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_carry_upd = 1'b1;
        case (w_op)
            c_OP_ADD: {w_alu_carry, w_alu_res} = {1'b0, r_opa} + {1'b0, rf_data_out};
            c_OP_SUB: begin
                w_alu_res   = r_opa - rf_data_out;
                w_alu_carry = (r_opa < rf_data_out);
            end
            c_OP_AND: w_alu_res = r_opa & rf_data_out;
            c_OP_OR:  w_alu_res = r_opa | rf_data_out;
            c_OP_XOR: w_alu_res = r_opa ^ rf_data_out;
            c_OP_SHL: begin
                w_alu_res   = r_opa << 1;
                w_alu_carry = r_opa[DATA_WIDTH-1];
            end
            c_OP_SHR: begin
                w_alu_res   = r_opa >> 1;
                w_alu_carry = r_opa[0];
            end
            c_OP_MOV: begin
                w_alu_res   = r_opa;
                w_carry_upd = 1'b0;
            end
            default:  w_carry_upd = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (instr_valid) w_state_nxt = f_is_alu(w_in_op) ? c_ST_RD_A : c_ST_WB;
            c_ST_RD_A: w_state_nxt = c_ST_RD_B;
            c_ST_RD_B: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC: w_state_nxt = c_ST_WB;
            c_ST_WB:   w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_instr   <= '0;
            r_opa     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (r_state == c_ST_WB);
            r_illegal <= (r_state == c_ST_WB) && (w_op > c_OP_MOV);
            if (w_accept) begin
                r_instr <= instr;
                // LDI skips EXEC, so its result and zero flag land here.
                if (w_in_op == c_OP_LDI) begin
                    r_result <= instr[DATA_WIDTH-1:0];
                    r_zero   <= (instr[DATA_WIDTH-1:0] == '0);
                end
            end
            if (r_state == c_ST_RD_B) begin
                r_opa <= rf_data_out;
            end
            if (r_state == c_ST_EXEC) begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                if (w_carry_upd) begin
                    r_carry <= w_alu_carry;
                end
            end
        end
    end

    // NOP and illegal opcodes pass through WB without writing.
    assign w_wb_write = (r_state == c_ST_WB) && (w_op != c_OP_NOP) && (w_op <= c_OP_MOV);

    // Reset gates the write combinationally so an abandoned WB never commits.
    assign rf_write_enable = w_wb_write && !reset;
    assign rf_write_addr   = rf_write_enable ? r_instr[11:9] : '0;
    assign rf_data_in      = rf_write_enable ? r_result : '0;

    always_comb begin
        rf_read_addr = '0;
        if (r_state == c_ST_RD_A) rf_read_addr = r_instr[8:6];
        if (r_state == c_ST_RD_B) rf_read_addr = r_instr[5:3];
    end

    assign instr_ready = (r_state == c_ST_IDLE);
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign zero_flag   = r_zero;
    assign carry_flag  = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_sequencer
//  Purpose  : Directed self-checking bench for exec_sequencer with a small
//             behavioural 8x8 register file (registered read) attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [2:0]  rf_read_addr;
    logic [7:0]  rf_data_out;
    logic [2:0]  rf_write_addr;
    logic [7:0]  rf_data_in;
    logic        rf_write_enable;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic        carry_flag;

    always #5 clk = ~clk;

    exec_sequencer #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .rf_read_addr    (rf_read_addr),
        .rf_data_out     (rf_data_out),
        .rf_write_addr   (rf_write_addr),
        .rf_data_in      (rf_data_in),
        .rf_write_enable (rf_write_enable),
        .done            (done),
        .illegal         (illegal),
        .zero_flag       (zero_flag),
        .carry_flag      (carry_flag)
    );

    // Behavioural register file: synchronous write, 1-cycle registered read.
    logic [7:0] r_mem [8] = '{default: 8'h00};
    logic [7:0] r_rdata = 8'h00;
    always @(posedge clk) begin
        if (rf_write_enable) r_mem[rf_write_addr] <= rf_data_in;
        r_rdata <= r_mem[rf_read_addr];
    end
    assign rf_data_out = r_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         cap_lat;
    int         cap_writes;
    logic [2:0] cap_wa;
    logic [7:0] cap_wd;
    logic [2:0] cap_ra [8];
    logic       cap_ill;

    // Issue one instruction from IDLE and follow it to its done cycle.
    // cap_lat counts the accept edge as 1, so the done cycle is cap_lat.
    task automatic issue(input logic [15:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
        check("ready_before_accept", 16'(instr_ready), 16'h1);
        tick();
        instr_valid = 1'b0;
        cap_lat    = 1;
        cap_writes = 0;
        cap_wa     = '0;
        cap_wd     = '0;
        while (!done && cap_lat < 12) begin
            if (rf_write_enable) begin
                cap_writes++;
                cap_wa = rf_write_addr;
                cap_wd = rf_data_in;
            end
            cap_ra[cap_lat[2:0]] = rf_read_addr;
            tick();
            cap_lat++;
        end
        cap_ill = illegal;
    endtask

    int busy;
    int writes;

    initial begin
        // Reset held for two cycles.
        tick();
        tick();
        check("rst_ready",  16'(instr_ready),     16'h1);
        check("rst_we",     16'(rf_write_enable), 16'h0);
        check("rst_done",   16'(done),            16'h0);
        check("rst_ill",    16'(illegal),         16'h0);
        check("rst_zf",     16'(zero_flag),       16'h0);
        check("rst_cf",     16'(carry_flag),      16'h0);
        check("rst_raddr",  16'(rf_read_addr),    16'h0);
        check("rst_wdata",  16'(rf_data_in),      16'h0);
        reset = 1'b0;
        tick();

        // LDI r1,0xF0
        issue(16'h82F0);
        check("ldi1_lat",    16'(cap_lat),    16'd2);
        check("ldi1_writes", 16'(cap_writes), 16'd1);
        check("ldi1_wa",     16'(cap_wa),     16'd1);
        check("ldi1_wd",     16'(cap_wd),     16'hF0);
        check("ldi1_zf",     16'(zero_flag),  16'h0);
        check("ldi1_ill",    16'(cap_ill),    16'h0);

        // LDI r2,0x20
        issue(16'h8420);
        check("ldi2_wd",     16'(cap_wd),     16'h20);

        // ADD r3,r1,r2 : 0xF0+0x20 = 0x110
        issue(16'h1650);
        check("add_lat",     16'(cap_lat),    16'd5);
        check("add_ra_rs1",  16'(cap_ra[1]),  16'd1);
        check("add_ra_rs2",  16'(cap_ra[2]),  16'd2);
        check("add_writes",  16'(cap_writes), 16'd1);
        check("add_wa",      16'(cap_wa),     16'd3);
        check("add_wd",      16'(cap_wd),     16'h10);
        check("add_cf",      16'(carry_flag), 16'h1);
        check("add_zf",      16'(zero_flag),  16'h0);

        // SUB r4,r1,r1 : zero result, no borrow
        issue(16'h2848);
        check("sub_wa",      16'(cap_wa),     16'd4);
        check("sub_wd",      16'(cap_wd),     16'h00);
        check("sub_zf",      16'(zero_flag),  16'h1);
        check("sub_cf",      16'(carry_flag), 16'h0);

        // SHR r5,r1 : 0xF0>>1 = 0x78, shifted-out bit 0
        issue(16'h7A40);
        check("shr_wa",      16'(cap_wa),     16'd5);
        check("shr_wd",      16'(cap_wd),     16'h78);
        check("shr_cf",      16'(carry_flag), 16'h0);
        check("shr_zf",      16'(zero_flag),  16'h0);

        // Back-to-back ADD r6,r1,r2 then ADD r7,r1,r1 with valid held high.
        busy   = 0;
        writes = 0;
        instr_valid = 1'b1;
        instr       = 16'h1C50;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (!instr_ready) busy++;
            if (rf_write_enable) writes++;
            tick();
        end
        check("b2b_done1",  16'(done),        16'h1);
        check("b2b_ready1", 16'(instr_ready), 16'h1);
        instr = 16'h1E48;
        tick();
        instr_valid = 1'b0;
        cap_wa = '0;
        cap_wd = '0;
        for (int c = 1; c <= 4; c++) begin
            if (!instr_ready) busy++;
            if (rf_write_enable) begin
                writes++;
                cap_wa = rf_write_addr;
                cap_wd = rf_data_in;
            end
            tick();
        end
        check("b2b_done2",  16'(done),       16'h1);
        check("b2b_busy",   16'(busy),       16'd8);
        check("b2b_writes", 16'(writes),     16'd2);
        check("b2b_wa2",    16'(cap_wa),     16'd7);
        check("b2b_wd2",    16'(cap_wd),     16'hE0);
        check("b2b_cf",     16'(carry_flag), 16'h1);
        check("b2b_r6",     16'(r_mem[6]),   16'h10);

        // Reset during EXEC of ADD r3,r1,r2: abandoned, no write.
        writes = 0;
        instr_valid = 1'b1;
        instr       = 16'h1650;
        r_mem[3]    = 8'h5A;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (rf_write_enable) writes++;
            tick();
        end
        check("rstx_ready",  16'(instr_ready),     16'h1);
        check("rstx_we",     16'(rf_write_enable), 16'h0);
        check("rstx_zf",     16'(zero_flag),       16'h0);
        check("rstx_cf",     16'(carry_flag),      16'h0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (rf_write_enable) writes++;
            tick();
        end
        check("rstx_writes", 16'(writes),   16'd0);
        check("rstx_r3",     16'(r_mem[3]), 16'h5A);
        check("rstx_done",   16'(done),     16'h0);

        // ADD r4,r1,r1 : 0xF0+0xF0 = 0x1E0 -> sets carry, clears zero.
        issue(16'h1848);
        check("add2_wd",     16'(cap_wd),     16'hE0);
        check("add2_cf",     16'(carry_flag), 16'h1);

        // LDI r2,0x00 : zero set, carry unchanged
        issue(16'h8400);
        check("ldi0_zf",     16'(zero_flag),  16'h1);
        check("ldi0_cf",     16'(carry_flag), 16'h1);

        // Illegal opcode: no write, illegal pulse, flags untouched.
        issue(16'hF000);
        check("ill_lat",     16'(cap_lat),    16'd2);
        check("ill_writes",  16'(cap_writes), 16'd0);
        check("ill_pulse",   16'(cap_ill),    16'h1);
        check("ill_zf",      16'(zero_flag),  16'h1);
        check("ill_cf",      16'(carry_flag), 16'h1);
        tick();
        check("ill_pulse_end", 16'(illegal),  16'h0);
        check("done_pulse_end", 16'(done),    16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multicycle execute/control stage directly upstream of the 8x8 register file.
- Accepts one instruction via a valid/ready handshake and fetches its operands through the register file's single synchronous read port (1-cycle registered read).
- Computes an 8-bit ALU result and writes it back through the register file's write port.
- Sole driver of the register file's read_addr, write_addr, data_in and write_enable.

Parameters:
- DATA_WIDTH, 8, operand/result width; instruction encoding below is defined for the default only.
- REG_ADDR_WIDTH, 3, register index width (8 registers).

Ports:
- clk  input  1  clock; all flops on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  high only in IDLE; transfer on valid&ready at a clk edge.
- instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8 (LDI only).
- rf_read_addr  output  3  to register file read_addr.
- rf_data_out  input  8  from register file data_out; valid 1 cycle after the address is presented.
- rf_write_addr  output  3  to register file write_addr.
- rf_data_in  output  8  to register file data_in.
- rf_write_enable  output  1  to register file write_enable.
- done  output  1  one-cycle pulse after each instruction retires.
- illegal  output  1  one-cycle pulse coincident with done for an undefined opcode.
- zero_flag  output  1  result==0 of the last flag-updating instruction.
- carry_flag  output  1  carry/borrow/shift-out of the last arithmetic or shift instruction.

Behaviour:
- Reset values: state=IDLE, instr_ready=1, rf_write_enable=0, rf_read_addr=0, rf_write_addr=0, rf_data_in=0, done=0, illegal=0, zero_flag=0, carry_flag=0.
- Reset mid-operation: the instruction is abandoned. No write occurs; rf_write_enable is 0 from the first reset cycle onward. Flags are cleared.
- States and transitions:
  - IDLE: on accept, latch instr, then go to RD_A. LDI, NOP and illegal opcodes go directly to WB.
  - RD_A: rf_read_addr=rs1. Go to RD_B.
  - RD_B: rf_read_addr=rs2; opa <= rf_data_out (rs1 value). Go to EXEC.
  - EXEC: result <= f(opa, rf_data_out); flags updated at the EXEC->WB edge. Go to WB.
  - WB: rf_write_enable=1 (except NOP/illegal), rf_write_addr=rd, rf_data_in=result. Go to IDLE.
- done/illegal are registered and high during the first IDLE cycle after WB. A new instruction may be accepted in that same cycle.
- Latency, accept edge to done: ALU ops 5 cycles; LDI/NOP/illegal 2 cycles.
- No read-after-write hazard: the write completes at the end of WB, before any later RD_A is sampled.
- Opcodes:
  - 0 NOP
  - 1 ADD: {carry,result}=opa+opb
  - 2 SUB: result=opa-opb, carry=borrow (opa<opb)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL: opa<<1, carry=opa[7]
  - 7 SHR: opa>>1 logical, carry=opa[0]
  - 8 LDI: result=imm8
  - 9 MOV: result=opa
  - 10-15 illegal
- Arithmetic: all results are truncated mod 256.
- Flag rules:
  - zero updated by ops 1-9.
  - carry updated by ops 1, 2, 6, 7; cleared by 3, 4, 5; unchanged by 8, 9.
  - NOP and illegal leave both flags unchanged.
- rd equal to rs1 or rs2 is legal; operands are read before the write.
- instr is ignored outside IDLE; holding instr_valid high while busy must not cause a duplicate accept.

Test Plan:
- Hold reset high 2 cycles -> instr_ready=1, rf_write_enable=0, done=0, zero_flag=0, carry_flag=0.
- LDI r1,0xF0 (instr=0x82F0) -> WB cycle with rf_write_enable=1, rf_write_addr=1, rf_data_in=0xF0; done on the next cycle, 2 cycles after accept; zero_flag=0.
- Run LDI r2,0x20 (0x8420), then ADD r3,r1,r2 (0x1650) -> r3=0x10, carry_flag=1, zero_flag=0, done 5 cycles after accept; rf_read_addr=1 in RD_A and 2 in RD_B.
- SUB r4,r1,r1 (0x2848) -> r4=0x00, zero_flag=1, carry_flag=0. Then SHR r5,r1 (0x7A40) -> r5=0x78, carry_flag=0.
- Present two ADDs back-to-back with instr_valid held high -> instr_ready=0 during RD_A..WB; the second ADD is accepted in the done cycle; exactly 2 writebacks occur.
- Assert reset in the EXEC cycle of ADD r3 -> no write to r3, state returns to IDLE, flags=0.
- Illegal opcode instr=0xF000 -> no write; done=1 and illegal=1 for one cycle; flags unchanged.
